// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the three-port memory arbiter: FSM states, owner codes
// and the request-vector bit positions used by the round-robin picker.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_D    = 2'd1;
  localparam logic [1:0] OWN_X    = 2'd2;
  localparam logic [1:0] OWN_I    = 2'd3;

  // Bit positions in the request vector, listed in rotation order D -> X -> I.
  localparam int REQ_D = 0;
  localparam int REQ_X = 1;
  localparam int REQ_I = 2;

  function automatic logic [1:0] onehot_to_own(input logic [2:0] oh);
    logic [1:0] own;
    own = OWN_NONE;
    case (oh)
      3'b001:  own = OWN_D;
      3'b010:  own = OWN_X;
      3'b100:  own = OWN_I;
      default: own = OWN_NONE;
    endcase
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick3.sv
// Combinational three-way round-robin picker: the requester following the
// last grantee (cyclic D -> X -> I) has the highest priority.
module rr_pick3
  import mem_port_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] win,
  output logic       valid
);

  logic [2:0] rot;
  logic [2:0] pick;

  // Rotate so the first-priority requester sits at bit 0, take the lowest
  // set bit, then rotate the one-hot result back.
  always_comb begin
    rot = req;
    case (last)
      OWN_D:   rot = {req[REQ_D], req[REQ_I], req[REQ_X]};
      OWN_X:   rot = {req[REQ_X], req[REQ_D], req[REQ_I]};
      default: rot = req;
    endcase

    pick = rot & (~rot + 3'd1);

    win = pick;
    case (last)
      OWN_D:   win = {pick[1], pick[0], pick[2]};
      OWN_X:   win = {pick[0], pick[2], pick[1]};
      default: win = pick;
    endcase

    valid = |req;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port registered-read memory among instruction fetch (I),
// load/store (D) and the IO master (X) with round-robin arbitration.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  // Handshake: a requester holds req and its fields stable until the single
  // cycle its ack is high, and may drop or replace them on the edge ending it.

  state_t            state, state_nx;
  logic [1:0]        owner, last_ptr;
  logic [2:0]        req_vec, mask, masked_req, win;
  logic              win_valid, grant;
  logic [1:0]        win_own;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

  assign req_vec = {i_req, x_req, d_req};

  // The requester being acked this cycle must not win again on the same edge.
  always_comb begin
    mask = 3'b000;
    if (state == ST_RESP) begin
      case (owner)
        OWN_D:   mask = 3'b001;
        OWN_X:   mask = 3'b010;
        OWN_I:   mask = 3'b100;
        default: mask = 3'b000;
      endcase
    end
    masked_req = req_vec & ~mask;
  end

  rr_pick3 u_pick (
    .req   (masked_req),
    .last  (last_ptr),
    .win   (win),
    .valid (win_valid)
  );

  assign win_own = onehot_to_own(win);

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nx = ST_ISSUE;
          grant    = 1'b1;
        end
      end
      ST_ISSUE: state_nx = ST_RESP;
      ST_RESP: begin
        if (win_valid) begin
          state_nx = ST_ISSUE;
          grant    = 1'b1;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_we   = 1'b0;
    sel_addr = i_addr;
    sel_din  = '0;
    case (win_own)
      OWN_D: begin
        sel_we   = d_we;
        sel_addr = d_addr;
        sel_din  = d_wdata;
      end
      OWN_X: begin
        sel_we   = x_we;
        sel_addr = x_addr;
        sel_din  = x_wdata;
      end
      default: begin
        sel_we   = 1'b0;
        sel_addr = i_addr;
        sel_din  = '0;
      end
    endcase
  end

  // mem_wen is a single-cycle strobe: it only survives the edge that grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner    <= OWN_NONE;
      last_ptr <= OWN_I;
      mem_wen  <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        owner    <= win_own;
        last_ptr <= win_own;
        mem_wen  <= sel_we;
        mem_addr <= sel_addr;
        mem_din  <= sel_din;
      end else begin
        mem_wen <= 1'b0;
      end
    end
  end

  assign d_ack = (state == ST_RESP) && (owner == OWN_D);
  assign x_ack = (state == ST_RESP) && (owner == OWN_X);
  assign i_ack = (state == ST_RESP) && (owner == OWN_I);
  assign rdata = mem_dout;
  assign gnt   = owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single-port transactions, hand-written
// multi-cycle sequences, then random traffic against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW       = 13;
  localparam int DW       = 32;
  localparam int RAND_CYC = 3000;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, d_req, d_we, x_req, x_we;
  logic [AW-1:0] i_addr, d_addr, x_addr;
  logic [DW-1:0] d_wdata, x_wdata;
  logic          i_ack, d_ack, x_ack;
  logic [DW-1:0] rdata;
  logic [1:0]    gnt;
  logic          mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata), .x_ack(x_ack),
    .rdata(rdata), .gnt(gnt),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory with registered read; a side port preloads contents.
  logic [DW-1:0] mem [0:8191];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_wen) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  // ---------------- scoreboard state ----------------
  int            n_cmp = 0;
  int            n_fail = 0;
  logic [DW-1:0] model_mem [0:8191];

  typedef struct {
    int            port;   // 0 = D, 1 = X, 2 = I
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_gnt;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    case (p)
      0: begin d_req = r; d_we = w; d_addr = a; d_wdata = wd; end
      1: begin x_req = r; x_we = w; x_addr = a; x_wdata = wd; end
      default: begin i_req = r; i_addr = a; end
    endcase
  endtask

  function automatic logic [2:0] ack_vec();
    return {i_ack, x_ack, d_ack};
  endfunction

  task automatic do_reset();
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] pre_val(input int a);
    if (a == 'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 ^ (a * 32'h00010001);
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 31);
    if (r < 24) return AW'(r);
    return AW'(13'h1FF8 + r - 24);
  endfunction

  // Round-robin rule: first candidate after the last grantee, cyclic D, X, I.
  function automatic int model_pick(input int last, input logic [2:0] cand);
    for (int k = 1; k <= 3; k++) begin
      if (cand[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  // One isolated transaction; reports latency, first-cycle mem fields, data.
  task automatic run_single(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, output int lat,
                            output logic [DW-1:0] rd, output logic [1:0] g,
                            output int wen_n, output logic [AW-1:0] a0,
                            output logic [DW-1:0] d0, output logic ok1);
    logic [2:0] av;
    lat = -1; wen_n = 0; ok1 = 1'b1; rd = '0; g = '0; a0 = '0; d0 = '0;
    drive(p, 1'b1, we, a, wd);
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      tick();
      if (n == 1) begin a0 = mem_addr; d0 = mem_din; end
      if (mem_wen) wen_n++;
      av = ack_vec();
      if (av != 3'b000) begin
        if (av != (3'b001 << p)) ok1 = 1'b0;
        lat = n; rd = rdata; g = gnt;
      end
    end
    tick();
    if (mem_wen) wen_n++;
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- random-phase bookkeeping ----------------
  logic [2:0]    req_hist [RAND_CYC];
  int            ack_hist [RAND_CYC];
  logic          pend [3];
  logic          rel [3];
  int            pstart [3];
  logic          rwe [3];
  logic [AW-1:0] raddr [3];
  logic [DW-1:0] rwd [3];

  task automatic new_req(input int p, input int t);
    rwe[p]    = (p == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    raddr[p]  = rand_addr();
    rwd[p]    = $urandom;
    pend[p]   = 1'b1;
    pstart[p] = t;
    drive(p, 1'b1, rwe[p], raddr[p], rwd[p]);
  endtask

  // ---------------- test ----------------
  initial begin
    int            lat, wen_n, last_m, ap, ep;
    logic [DW-1:0] rd;
    logic [1:0]    g;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          ok1, ovl, quiet, inext, dnext;
    logic [2:0]    av, cand, exp_av;
    int            alog[$];
    int            sim_exp[3];
    int            fair_exp[4];
    logic [DW-1:0] sim_rd[3];

    tbl[0] = '{2, 1'b0, 13'h0010, 32'h0,        32'hDEADBEEF, 2'd3};
    tbl[1] = '{1, 1'b1, 13'h1FFF, 32'h12345678, 32'h0,        2'd2};
    tbl[2] = '{1, 1'b0, 13'h1FFF, 32'h0,        32'h12345678, 2'd2};
    tbl[3] = '{0, 1'b1, 13'h0005, 32'h11112222, 32'h0,        2'd1};
    tbl[4] = '{0, 1'b0, 13'h0005, 32'h0,        32'h11112222, 2'd1};
    tbl[5] = '{0, 1'b0, 13'h1FFF, 32'h0,        32'h12345678, 2'd1};
    tbl[6] = '{2, 1'b0, 13'h0005, 32'h0,        32'h11112222, 2'd3};
    sim_exp  = '{102, 204, 306};
    fair_exp = '{102, 304, 106, 109};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    drive(2, 1'b0, 1'b0, '0, '0);
    #1;
    chk("reset_mem_wen", mem_wen, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_din", mem_din, 0);
    chk("reset_acks", ack_vec(), 0);
    chk("reset_gnt", gnt, 0);

    // Preload while held in reset.
    for (int i = 0; i < 64; i++) begin
      int a;
      a = (i < 32) ? i : ('h1FE0 + i - 32);
      pre_addr = AW'(a); pre_data = pre_val(a); pre_we = 1'b1;
      model_mem[a] = pre_val(a);
      tick();
    end
    pre_we = 1'b0;
    do_reset();

    // Table-driven single transactions.
    for (int k = 0; k < 7; k++) begin
      run_single(tbl[k].port, tbl[k].we, tbl[k].addr, tbl[k].wdata,
                 lat, rd, g, wen_n, a0, d0, ok1);
      chk($sformatf("tbl%0d_latency", k), lat, 2);
      chk($sformatf("tbl%0d_mem_addr", k), a0, tbl[k].addr);
      chk($sformatf("tbl%0d_wen_cycles", k), wen_n, tbl[k].we ? 1 : 0);
      chk($sformatf("tbl%0d_ack_port", k), ok1, 1);
      chk($sformatf("tbl%0d_gnt", k), g, tbl[k].exp_gnt);
      if (tbl[k].we) begin
        chk($sformatf("tbl%0d_mem_din", k), d0, tbl[k].wdata);
        model_mem[tbl[k].addr] = tbl[k].wdata;
      end else begin
        chk($sformatf("tbl%0d_rdata", k), rd, tbl[k].exp_rdata);
      end
    end

    // Simultaneous requests right after reset: D, X, I in that order.
    do_reset();
    drive(0, 1'b1, 1'b0, 13'h0001, '0);
    drive(1, 1'b1, 1'b0, 13'h0002, '0);
    drive(2, 1'b1, 1'b0, 13'h0003, '0);
    alog.delete();
    ovl = 1'b0;
    av = 3'b000;
    for (int n = 1; n <= 8; n++) begin
      logic [2:0] prev;
      prev = av;
      tick();
      for (int p = 0; p < 3; p++) if (prev[p]) drive(p, 1'b0, 1'b0, '0, '0);
      av = ack_vec();
      if ($countones(av) > 1) ovl = 1'b1;
      for (int p = 0; p < 3; p++) begin
        if (av[p]) begin
          alog.push_back((p + 1) * 100 + n);
          sim_rd[p] = rdata;
          chk($sformatf("sim_gnt_p%0d", p), gnt, p + 1);
        end
      end
    end
    chk("sim_no_overlap", ovl, 0);
    chk("sim_ack_count", alog.size(), 3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("sim_ack%0d", k), (k < alog.size()) ? alog[k] : -1, sim_exp[k]);
    for (int p = 0; p < 3; p++)
      chk($sformatf("sim_rdata_p%0d", p), sim_rd[p], model_mem[p + 1]);

    // Fairness: D streams continuously, I asks once.
    do_reset();
    drive(0, 1'b1, 1'b0, 13'h0004, '0);
    drive(2, 1'b1, 1'b0, 13'h0006, '0);
    alog.delete();
    inext = 1'b0; dnext = 1'b0;
    for (int n = 1; n <= 11; n++) begin
      tick();
      if (inext) drive(2, 1'b0, 1'b0, '0, '0);
      if (dnext) drive(0, 1'b1, 1'b0, AW'(4 + n), '0);
      inext = 1'b0; dnext = 1'b0;
      av = ack_vec();
      if (av[0]) begin alog.push_back(100 + n); dnext = 1'b1; end
      if (av[1]) alog.push_back(200 + n);
      if (av[2]) begin alog.push_back(300 + n); inext = 1'b1; end
    end
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair_ack%0d", k), (k < alog.size()) ? alog[k] : -1, fair_exp[k]);

    // Reset while a D write sits in ISSUE.
    do_reset();
    drive(0, 1'b1, 1'b1, 13'h0005, 32'hAAAA5555);
    tick();
    chk("abort_wen_before", mem_wen, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_wen_async", mem_wen, 0);
    chk("abort_gnt_async", gnt, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    quiet = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (ack_vec() != 3'b000) quiet = 1'b0;
    end
    chk("abort_no_ack", quiet, 1);
    run_single(0, 1'b0, 13'h0005, '0, lat, rd, g, wen_n, a0, d0, ok1);
    chk("abort_old_data", rd, 32'h11112222);
    chk("abort_read_latency", lat, 2);

    // Idle for 20 cycles: nothing moves, gnt keeps the last owner (D).
    quiet = 1'b1;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (mem_wen || ack_vec() != 3'b000 || gnt != 2'd1) quiet = 1'b0;
    end
    chk("idle_quiet", quiet, 1);
    chk("idle_gnt", gnt, 1);
    run_single(2, 1'b0, 13'h0010, '0, lat, rd, g, wen_n, a0, d0, ok1);
    chk("idle_then_read_latency", lat, 2);
    chk("idle_then_read_rdata", rd, 32'hDEADBEEF);

    // Random traffic against the transaction-level model.
    do_reset();
    last_m = 2;
    for (int p = 0; p < 3; p++) begin pend[p] = 1'b0; rel[p] = 1'b0; pstart[p] = 0; end
    for (int t = 0; t < RAND_CYC; t++) begin
      tick();
      av = ack_vec();
      ep = -1;
      // A grant can only happen on an edge where no access was in ISSUE.
      if (t >= 2 && ack_hist[t-1] < 0) begin
        cand = req_hist[t-2];
        if (ack_hist[t-2] >= 0) cand[ack_hist[t-2]] = 1'b0;
        ep = model_pick(last_m, cand);
      end
      exp_av = 3'b000;
      if (ep >= 0) exp_av[ep] = 1'b1;
      chk($sformatf("rand_ack_t%0d", t), av, exp_av);
      if (ep >= 0) begin
        ap = ep;
        chk($sformatf("rand_gnt_t%0d", t), gnt, ap + 1);
        last_m = ap;
        if (rwe[ap]) model_mem[raddr[ap]] = rwd[ap];
        else chk($sformatf("rand_rdata_t%0d", t), rdata, model_mem[raddr[ap]]);
        chk($sformatf("rand_wait_t%0d", t), (t - pstart[ap]) <= 6, 1);
      end
      ack_hist[t] = ep;
      for (int p = 0; p < 3; p++) begin
        if (rel[p]) begin
          rel[p] = 1'b0;
          if ($urandom_range(0, 1) == 1) new_req(p, t);
          else begin pend[p] = 1'b0; drive(p, 1'b0, 1'b0, '0, '0); end
        end else if (!pend[p] && $urandom_range(0, 99) < 35) begin
          new_req(p, t);
        end
      end
      if (ep >= 0) rel[ep] = 1'b1;
      req_hist[t] = {pend[2], pend[1], pend[0]};
    end
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Three-port arbiter that shares the single-port 8192×32 instruction/data memory among the CPU instruction fetch (I), the CPU load/store unit (D) and the external IO/polling master (X). It sits between the requesters and the memory. It serialises their accesses with round-robin fairness and absorbs the memory's one-cycle registered read latency behind a req/ack handshake.

## Interface
Parameters:
- ADDR_W, 13, memory word-address width
- DATA_W, 32, memory data width

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  instruction-fetch request (read only)
- i_addr  in  ADDR_W  instruction word address
- i_ack  out  1  one-cycle completion pulse for I
- d_req  in  1  load/store request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  completion pulse for D
- x_req  in  1  IO master request
- x_we  in  1  1 = write, 0 = read
- x_addr  in  ADDR_W  IO master word address
- x_wdata  in  DATA_W  IO master write data
- x_ack  out  1  completion pulse for X
- rdata  out  DATA_W  shared read-return bus; valid only while an ack is high for a read
- gnt  out  2  current or last owner: 0 = none, 1 = D, 2 = X, 3 = I (debug)
- mem_wen  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_din  out  DATA_W  memory write data (registered)
- mem_dout  in  DATA_W  memory registered read data

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if any req is high, pick a winner at the edge. Load mem_addr, mem_wen (the winner's we; always 0 for I) and mem_din. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE: the memory performs the access at the closing edge. At that edge mem_wen <= 0 and the FSM goes to RESP.
- RESP: the winner's ack = 1. rdata = mem_dout, combinational passthrough.
  - For a write, rdata is don't-care.
  - During RESP the acked requester's req is masked from arbitration. At the closing edge, the FSM arbitrates among the other reqs: winner → ISSUE, none → IDLE.
- Requester rules:
  - Hold req, addr, we and wdata stable from assertion until the ack cycle.
  - Drop req, or present a new request, on the edge ending the ack cycle.
  - Changing fields before ack is a protocol violation. The result is undefined.
- Round-robin: a 2-bit last-grant pointer is updated on every grant. Priority order starts after the last grantee, cyclic D → X → I.
- Only one ack is high in any cycle. ack and gnt are decoded from state and the owner register.

## Timing
- Reset values: mem_wen 0, mem_addr 0, mem_din 0, all acks 0, gnt 0, state IDLE, last pointer = I (so D has first priority).
- Reset is asynchronous. A write sitting in ISSUE is aborted before its edge because mem_wen clears immediately. No ack is issued for the aborted access.
- Latency: req high before edge E0 → access issued at E0 → memory operates at E1 → ack high in the cycle after E1. That is 2 cycles from the sampling edge to the ack.
- Sustained throughput: one access per 2 cycles. The sequence RESP → ISSUE → RESP runs with no IDLE bubble when other requests are pending.
- Simultaneous requests: the winner is decided solely by the pointer. Losers wait with no lost request.
- A requester with a continuous stream is granted at most once per rotation while others wait. Worst-case wait is 4 cycles of other traffic plus its own 2.
- Read after write to the same address, in back-to-back grants, returns the new data.

## Structure
- Shared package: ADDR_W/DATA_W defaults, the state enum (IDLE, ISSUE, RESP) and the owner encodings (NONE = 0, D = 1, X = 2, I = 3).
- One sub-module: rr_pick3, combinational. Inputs are the 3-bit masked request vector and the last pointer. Outputs are a one-hot winner and a valid flag.
- The top holds the FSM, the owner and pointer registers, the mem_* registers and the ack/rdata decode.

## Test plan
- Single I read: memory word 0x0010 = 0xDEADBEEF; i_req pulse → mem_addr = 0x0010 at E0, i_ack and rdata = 0xDEADBEEF two cycles later, gnt = 3.
- Write then read, X port: x_we = 1, x_addr = 0x1FFF, x_wdata = 0x12345678 → x_ack, mem_wen high for exactly one cycle. Then x read of 0x1FFF → rdata = 0x12345678.
- All three requests in the same cycle after reset → grants in order D, X, I. The acks land in cycles 2, 4 and 6. No overlapping acks.
- Fairness: d_req held continuously with back-to-back requests, i_req asserted once → I is granted no later than after one D access. Grants alternate D, I.
- Reset mid-write: assert rst while in ISSUE with a D write to 0x0005 = 0xAAAA5555 → mem_wen drops immediately, no d_ack. A subsequent read of 0x0005 returns the old value.
- Idle: no requests for 20 cycles → state IDLE, mem_wen = 0, all acks 0, gnt unchanged.
